// File: rtl/bus_ctrl_pkg.sv
// Shared encodings for the register-bus sequencer.
// Opcodes, register select codes and the controller state type.
package bus_ctrl_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_MOVE = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;

  localparam logic [1:0] REG_A = 2'b00;
  localparam logic [1:0] REG_B = 2'b01;
  localparam logic [1:0] REG_C = 2'b10;
  localparam logic [1:0] REG_D = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DRIVE    = 3'd1,
    S_ADD_EXEC = 3'd2,
    S_ADD_WB   = 3'd3,
    S_DONE     = 3'd4,
    S_ERR      = 3'd5
  } state_e;

endpackage

// File: rtl/reg_sel_decode.sv
// 2-to-4 one-hot register select decoder with enable.
// Ports: en_i enable, sel_i register code, onehot_o {D,C,B,A}.
module reg_sel_decode (
  input  logic       en_i,
  input  logic [1:0] sel_i,
  output logic [3:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/bus_sequencer.sv
// Command sequencer for the shared 16-bit register bus.
// Ports: clock/reset, cmd_* handshake, busy/done/err status,
// op_count, bus driver enables, register loads, enbAdd.
module bus_sequencer
  import bus_ctrl_pkg::*;
#(
  parameter int ADD_LAT = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [1:0]       cmd_src,
  input  logic [1:0]       cmd_dst,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] op_count,
  output logic             enbIn,
  output logic             enbA,
  output logic             enbB,
  output logic             enbC,
  output logic             enbD,
  output logic             enbBusA,
  output logic             ldA,
  output logic             ldB,
  output logic             ldC,
  output logic             ldD,
  output logic             enbAdd
);

  localparam logic [3:0] LAT_INIT = 4'(ADD_LAT - 1);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       src_q, src_d;
  logic [1:0]       dst_q, dst_d;
  logic [3:0]       lat_q, lat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0] src_en_q, src_en_d;
  logic [3:0] ld_q, ld_d;
  logic       in_q, in_d;
  logic       busa_q, busa_d;
  logic       add_q, add_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;
  logic       rdy_q, rdy_d;

  logic accept;
  logic mv_en;
  logic wr_en;

  // Ready is held low while reset is asserted, so no
  // command can be taken during the reset cycle.
  assign cmd_ready = rdy_q & ~reset;
  assign accept    = cmd_valid & cmd_ready;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    lat_d   = lat_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = cmd_op;
          src_d = cmd_src;
          dst_d = cmd_dst;
          unique case (cmd_op)
            OP_LOAD,
            OP_MOVE: state_d = S_DRIVE;
            OP_ADD: begin
              state_d = S_ADD_EXEC;
              lat_d   = LAT_INIT;
            end
            default: state_d = S_ERR;
          endcase
        end
      end
      S_DRIVE: begin
        state_d = S_DONE;
        cnt_d   = cnt_q + 1'b1;
      end
      S_ADD_EXEC: begin
        if (lat_q == '0) state_d = S_ADD_WB;
        else             lat_d   = lat_q - 1'b1;
      end
      S_ADD_WB: begin
        state_d = S_DONE;
        cnt_d   = cnt_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so that the
  // registered copies line up with the state they belong to.
  assign mv_en  = (state_d == S_DRIVE) && (op_d == OP_MOVE);
  assign wr_en  = (state_d == S_DRIVE) ||
                  (state_d == S_ADD_WB);
  assign in_d   = (state_d == S_DRIVE) && (op_d == OP_LOAD);
  assign busa_d = (state_d == S_ADD_WB);
  assign add_d  = (state_d == S_ADD_EXEC);
  assign done_d = (state_d == S_DONE);
  assign err_d  = (state_d == S_ERR);
  assign busy_d = (state_d != S_IDLE);
  assign rdy_d  = (state_d == S_IDLE);

  reg_sel_decode u_src_dec (
    .en_i     (mv_en),
    .sel_i    (src_d),
    .onehot_o (src_en_d)
  );

  reg_sel_decode u_ld_dec (
    .en_i     (wr_en),
    .sel_i    (dst_d),
    .onehot_o (ld_d)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      lat_q    <= '0;
      cnt_q    <= '0;
      src_en_q <= '0;
      ld_q     <= '0;
      in_q     <= 1'b0;
      busa_q   <= 1'b0;
      add_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      lat_q    <= lat_d;
      cnt_q    <= cnt_d;
      src_en_q <= src_en_d;
      ld_q     <= ld_d;
      in_q     <= in_d;
      busa_q   <= busa_d;
      add_q    <= add_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      rdy_q    <= rdy_d;
    end
  end

  assign enbIn    = in_q;
  assign enbA     = src_en_q[0];
  assign enbB     = src_en_q[1];
  assign enbC     = src_en_q[2];
  assign enbD     = src_en_q[3];
  assign enbBusA  = busa_q;
  assign ldA      = ld_q[0];
  assign ldB      = ld_q[1];
  assign ldC      = ld_q[2];
  assign ldD      = ld_q[3];
  assign enbAdd   = add_q;
  assign done     = done_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign op_count = cnt_q;

endmodule
